// File: rtl/mrv_ctrl_pkg.sv
// Shared types and select encodings for the miniRV multi-cycle controller.
package mrv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } ctrl_state_t;

  localparam logic ADDR_SEL_PC  = 1'b0;
  localparam logic ADDR_SEL_ALU = 1'b1;
  localparam logic PC_SEL_SEQ   = 1'b0;
  localparam logic PC_SEL_JALR  = 1'b1;

  // States that own the shared memory port and therefore wait on mem_ready.
  function automatic logic is_mem_state(input ctrl_state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/mrv_wait_timer.sv
// Counts stalled memory cycles; expired flags the last permitted stall cycle.
module mrv_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic unused_in;
      assign unused_in = ^{clk, rst, clr, tick};
      assign expired   = 1'b0;
    end else begin : g_on
      localparam int W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
      localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);
      logic [W-1:0] count;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)       count <= '0;
        else if (clr)  count <= '0;
        else if (tick) count <= count + W'(1);
      end

      assign expired = tick && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/mrv_multicycle_ctrl.sv
// miniRV multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB over one memory port,
// with sticky halt on illegal instruction or memory timeout.
module mrv_multicycle_ctrl
  import mrv_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mem_ready,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_pc_src,
  input  logic             dec_illegal,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             rf_we,
  output logic             halted,
  output logic             timeout_err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  ctrl_state_t cur, nxt;
  logic        waiting;
  logic        expired;
  logic        retire;

  assign waiting = is_mem_state(cur);

  // Timer is held clear outside the memory states and on every completed access.
  mrv_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!waiting || mem_ready),
    .tick    (waiting && !mem_ready),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur         <= ST_IDLE;
      timeout_err <= 1'b0;
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cur <= nxt;
      if (expired)
        timeout_err <= 1'b1;
      if (cur != ST_IDLE && cur != ST_HALT)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire)
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    nxt          = cur;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = ADDR_SEL_PC;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_SEQ;
    rf_we        = 1'b0;
    retire       = 1'b0;
    case (cur)
      ST_IDLE: begin
        if (en) nxt = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          nxt   = ST_DECODE;
        end else if (expired) begin
          nxt = ST_HALT;
        end
      end
      ST_DECODE: begin
        nxt = dec_illegal ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        nxt = (dec_mem_read || dec_mem_write) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = ADDR_SEL_ALU;
        mem_we       = dec_mem_write;
        if (mem_ready) begin
          // Stores have nothing to write back, so they retire on the ack.
          if (dec_mem_write) begin
            pc_we  = 1'b1;
            retire = 1'b1;
            nxt    = en ? ST_FETCH : ST_IDLE;
          end else begin
            nxt = ST_WB;
          end
        end else if (expired) begin
          nxt = ST_HALT;
        end
      end
      ST_WB: begin
        rf_we  = dec_reg_write;
        pc_we  = 1'b1;
        pc_sel = dec_pc_src;
        retire = 1'b1;
        nxt    = en ? ST_FETCH : ST_IDLE;
      end
      ST_HALT: begin
        nxt = ST_HALT;
      end
      default: begin
        nxt = ST_IDLE;
      end
    endcase
  end

  assign halted = (cur == ST_HALT);
  assign state  = cur;

endmodule
